// File: rtl/mult_issue_seq_if.sv
// Bus bundle for the multiplier operand sequencer: operand stream in,
// multiplier start/operands/product, and the result stream out.
// The slave modport is the sequencer's view; master is its environment.
interface mult_issue_seq_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;

    logic           mult_start;
    logic [N-1:0]   mult_multiplier;
    logic [N-1:0]   mult_multiplicand;
    logic [2*N-1:0] mult_product;
    logic           mult_valid;

    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_product;

    modport slave (
        input  in_valid, in_a, in_b,
        output in_ready,
        output mult_start, mult_multiplier, mult_multiplicand,
        input  mult_product, mult_valid,
        output out_valid, out_product,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b,
        input  in_ready,
        input  mult_start, mult_multiplier, mult_multiplicand,
        output mult_product, mult_valid,
        input  out_valid, out_product,
        output out_ready
    );
endinterface

// File: rtl/mult_issue_seq.sv
// Operand sequencer for the ripple-carry multiplier. Operand pairs are
// queued in a small FIFO, issued one at a time with a single-cycle start
// pulse, and the product is captured into a ready/valid output register.
// A watchdog abandons an operation whose product never arrives.
module mult_issue_seq #(
    parameter int N       = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    mult_issue_seq_if.slave        bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   timeout_err,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [N-1:0]   mem_a [DEPTH];
    logic [N-1:0]   mem_b [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [WW-1:0]  wd_cnt;

    logic           push;
    logic           pop;
    logic           take_result;
    logic           wd_expire;
    logic           out_fire;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign bus.in_ready = (fifo_count < FULL_CNT);
    assign push         = bus.in_valid && bus.in_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;

    // Next-state and per-cycle strobes; the product beats the watchdog
    // when both land on the same edge.
    always_comb begin
        state_nxt   = state;
        pop         = 1'b0;
        take_result = 1'b0;
        wd_expire   = 1'b0;
        unique case (state)
            IDLE: begin
                if ((fifo_count != '0) && !bus.out_valid) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mult_valid) begin
                    take_result = 1'b1;
                    state_nxt   = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    wd_expire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FIFO storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= bus.in_a;
            mem_b[wr_ptr] <= bus.in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Issue register: start pulses for exactly the ISSUE cycle, operands hold
    // their last issued values until the next pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mult_start        <= 1'b0;
            bus.mult_multiplier   <= '0;
            bus.mult_multiplicand <= '0;
        end else begin
            bus.mult_start <= pop;
            if (pop) begin
                bus.mult_multiplier   <= mem_a[rd_ptr];
                bus.mult_multiplicand <= mem_b[rd_ptr];
            end
        end
    end

    // Watchdog counter: zeroed while the start pulse is out, counts WAIT cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ISSUE) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + WW'(1);
        end
    end

    // Result register: loads on the multiplier's valid, drains on handshake,
    // and holds the product steady under back-pressure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid   <= 1'b0;
            bus.out_product <= '0;
        end else if (take_result) begin
            bus.out_valid   <= 1'b1;
            bus.out_product <= bus.mult_product;
        end else if (out_fire) begin
            bus.out_valid   <= 1'b0;
        end
    end

    // Sticky watchdog flag; a set on the same edge as a clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (wd_expire) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mult_issue_seq.sv
// Bench for mult_issue_seq: a multiplier stub, a transaction-level reference
// model compared on every cycle, directed scenarios and a randomized soak.
module tb_mult_issue_seq;
    localparam int N       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          err_clr;
    logic [CW-1:0] fifo_count;
    logic          timeout_err;

    mult_issue_seq_if #(.N(N)) bus ();

    mult_issue_seq #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .fifo_count  (fifo_count),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
    } pair_t;

    pair_t          q[$];
    bit             m_busy;
    bit             m_start;
    bit             m_ov;
    bit             m_err;
    int             m_waited;
    logic [N-1:0]   m_a;
    logic [N-1:0]   m_b;
    logic [2*N-1:0] m_prod;

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_start = 0; m_ov = 0; m_err = 0; m_waited = 0;
        m_a = '0; m_b = '0; m_prod = '0;
    endtask

    task automatic model_step();
        bit    do_push;
        bit    had_ov;
        pair_t p;
        do_push = bus.in_valid && (q.size() < DEPTH);
        had_ov  = m_ov;
        if (m_ov && bus.out_ready) m_ov = 0;
        if (err_clr) m_err = 0;
        if (!m_busy) begin
            if (q.size() > 0 && !had_ov) begin
                p = q.pop_front();
                m_a = p.a; m_b = p.b;
                m_start = 1; m_busy = 1; m_waited = 0;
            end
        end else if (m_start) begin
            m_start = 0;
        end else begin
            m_waited++;
            if (bus.mult_valid) begin
                m_prod = bus.mult_product; m_ov = 1; m_busy = 0;
            end else if (m_waited == TIMEOUT) begin
                m_err = 1; m_busy = 0;
            end
        end
        if (do_push) begin
            p.a = bus.in_a; p.b = bus.in_b;
            q.push_back(p);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("in_ready",    bus.in_ready, (q.size() < DEPTH));
                chk("fifo_count",  fifo_count, q.size());
                chk("mult_start",  bus.mult_start, m_start);
                chk("multiplier",  bus.mult_multiplier, m_a);
                chk("multiplicand", bus.mult_multiplicand, m_b);
                chk("out_valid",   bus.out_valid, m_ov);
                chk("out_product", bus.out_product, m_prod);
                chk("timeout_err", timeout_err, m_err);
            end
        end
    end

    // ---------------- monitors ----------------
    int             start_cnt = 0;
    logic [63:0]    got[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.mult_start) start_cnt++;
                if (bus.out_valid && bus.out_ready) got.push_back(bus.out_product);
            end
        end
    end

    // ---------------- multiplier stub ----------------
    int             stub_lat   = 3;
    bit             stub_never = 0;
    bit             inject     = 0;
    int             stub_cnt   = 0;
    logic [2*N-1:0] stub_prod  = '0;

    initial begin
        bus.mult_valid   = 1'b0;
        bus.mult_product = '0;
        forever begin
            @(negedge clk);
            bus.mult_valid   = 1'b0;
            bus.mult_product = {$urandom(), $urandom()};
            if (reset) begin
                stub_cnt = 0;
            end else if (bus.mult_start) begin
                stub_cnt  = stub_never ? 0 : stub_lat;
                stub_prod = 64'(bus.mult_multiplier) * 64'(bus.mult_multiplicand);
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    bus.mult_valid   = 1'b1;
                    bus.mult_product = stub_prod;
                end
            end
            if (inject) begin
                bus.mult_valid   = 1'b1;
                bus.mult_product = 64'hDEAD_BEEF_0BAD_F00D;
                inject = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string name);
        int k = 0;
        while (got.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (got.size() < n) begin
            checks++; errors++;
            $display("FAIL %s: timed out with %0d results, expected %0d", name, got.size(), n);
        end
    endtask

    function automatic logic [63:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 64'hXXXX_XXXX_XXXX_XXXX;
    endfunction

    task automatic wait_out_valid(input string name);
        int k = 0;
        while (!bus.out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, bus.out_valid, 1'b1);
    endtask

    logic [N-1:0] ra;
    logic [N-1:0] rb;

    function automatic logic [N-1:0] pick_operand();
        unique case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          k;
        int          s0;
        logic [63:0] p0;

        reset = 1'b1; err_clr = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Single operation: 1256 * 256.
        got.delete();
        s0 = start_cnt;
        stub_lat = 3;
        push(32'd1256, 32'd256);
        wait_results(1, "single_wait");
        chk("single_product", got_at(0), 64'd321536);
        chk("single_starts", start_cnt - s0, 1);

        // FIFO full and ordering, behind a held result.
        tick();
        bus.out_ready = 1'b0;
        push(32'd11, 32'd2);
        wait_out_valid("hold_valid");
        tick();
        push(32'd3, 32'd5);
        push(32'd7, 32'd9);
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push(32'd0, 32'd123);
        @(negedge clk);
        chk("full_count", fifo_count, 4);
        chk("full_in_ready", bus.in_ready, 1'b0);
        tick();
        push(32'd99, 32'd99);
        @(negedge clk);
        chk("blocked_count", fifo_count, 4);
        tick();
        got.delete();
        bus.out_ready = 1'b1;
        wait_results(5, "order_wait");
        chk("order0", got_at(0), 64'd22);
        chk("order1", got_at(1), 64'd15);
        chk("order2", got_at(2), 64'd63);
        chk("order3", got_at(3), 64'hFFFF_FFFE_0000_0001);
        chk("order4", got_at(4), 64'd0);

        // Output back-pressure.
        tick();
        got.delete();
        bus.out_ready = 1'b0;
        stub_lat = 2;
        push(32'd5, 32'd6);
        push(32'd7, 32'd8);
        wait_out_valid("bp_valid");
        p0 = bus.out_product;
        s0 = start_cnt;
        chk("bp_first", p0, 64'd30);
        repeat (6) begin
            @(negedge clk);
            chk("bp_hold", bus.out_product, p0);
        end
        chk("bp_no_start", start_cnt - s0, 0);
        tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mult_start && k < 20);
        chk("bp_restart_delay", k, 2);
        tick();
        bus.out_ready = 1'b1;
        wait_results(2, "bp_wait");
        chk("bp_second", got_at(1), 64'd56);

        // Watchdog: first op never answered, second issues normally.
        tick();
        got.delete();
        stub_never = 1;
        stub_lat = 3;
        push(32'd2, 32'd3);
        push(32'd4, 32'd5);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mult_start && k < 50);
        #1 stub_never = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err && k < 60);
        chk("wd_cycles", k, TIMEOUT + 1);
        chk("wd_no_result", got.size(), 0);
        wait_results(1, "wd_next_wait");
        chk("wd_next_product", got_at(0), 64'd20);
        chk("wd_sticky", timeout_err, 1'b1);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("err_clr", timeout_err, 1'b0);

        // Set and clear on the same edge: set wins, next clear drops it.
        tick();
        err_clr = 1'b1;
        stub_never = 1;
        push(32'd9, 32'd9);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mult_start && k < 50);
        #1 stub_never = 0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_err && k < 60);
        chk("set_wins", timeout_err, 1'b1);
        @(negedge clk);
        chk("clear_after_set", timeout_err, 1'b0);
        tick();
        err_clr = 1'b0;

        // Reset during WAIT with two entries queued.
        tick();
        stub_lat = 8;
        push(32'd1, 32'd1);
        push(32'd2, 32'd2);
        push(32'd3, 32'd3);
        repeat (2) @(negedge clk);
        chk("pre_reset_count", fifo_count, 2);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_count", fifo_count, 0);
        chk("rst_start", bus.mult_start, 1'b0);
        chk("rst_mplier", bus.mult_multiplier, 0);
        chk("rst_mcand", bus.mult_multiplicand, 0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_product", bus.out_product, 0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        repeat (5) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1'b1);
        tick();
        inject = 1;
        repeat (8) begin
            @(negedge clk);
            chk("late_valid_ignored", bus.out_valid, 1'b0);
            chk("late_no_start", bus.mult_start, 1'b0);
        end

        // Randomized soak.
        tick();
        for (int c = 0; c < 3000; c++) begin
            ra = pick_operand();
            rb = pick_operand();
            bus.in_valid  = ($urandom_range(0, 99) < 40);
            bus.in_a      = ra;
            bus.in_b      = rb;
            bus.out_ready = ($urandom_range(0, 99) < 60);
            err_clr       = ($urandom_range(0, 99) < 5);
            stub_lat      = $urandom_range(1, 8);
            stub_never    = ($urandom_range(0, 99) < 8);
            reset         = ($urandom_range(0, 499) == 0);
            tick();
        end
        bus.in_valid = 1'b0; reset = 1'b0; err_clr = 1'b0;
        bus.out_ready = 1'b1; stub_never = 0;
        repeat (40) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
